// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier result path: reader FSM
// states, result word geometry and the output-select width.
package matrix_pkg;

  localparam int MAT_GRP_WORDS = 4;
  localparam int MAT_DATA_W    = 18;
  localparam int MAT_SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GRP = 2'd1,
    READ     = 2'd2,
    DRAIN    = 2'd3
  } rdr_state_t;

endpackage

// File: rtl/matrix_result_fifo.sv
// Synchronous FIFO buffering captured result words. The pointers carry an
// extra wrap bit so that full and empty can be told apart.
module matrix_result_fifo #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/matrix_result_reader.sv
// Steps p_sel through each result group of matrixTOP, captures P_out words
// into a FIFO and streams them out on valid/ready with a last-word tag.
module matrix_result_reader
  import matrix_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = MAT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  grp_ready,
  output logic [MAT_SEL_W-1:0]  p_sel,
  input  logic [DATA_W-1:0]     p_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_grp,
  output logic [1:0]            fsm_state
);

  // Stream handshake: a word transfers on a cycle where m_valid and m_ready
  // are both high; m_valid/m_data hold until that transfer occurs.

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GRP_W = $clog2(NUM_GROUPS + 1);

  rdr_state_t          state;
  rdr_state_t          state_n;
  logic [GRP_W-1:0]    grp_cnt;
  logic [MAT_SEL_W-1:0] sel_cnt;
  logic                pend;
  logic                pend_last;
  logic                cap_valid;
  logic                cap_last;
  logic [DATA_W-1:0]   cap_data;

  logic [DATA_W:0]     fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    free_slots;
  logic [CNT_W-1:0]    inflight;

  logic                issue;
  logic                last_sel;
  logic                grp_last;
  logic                start_ok;
  logic                fin;

  assign free_slots = fifo_full ? '0 : (CNT_W'(FIFO_DEPTH) - fifo_count);
  // Words already selected or captured but not yet in the FIFO.
  assign inflight   = CNT_W'(pend) + CNT_W'(cap_valid);
  assign issue      = (state == READ) && (free_slots > inflight);
  assign last_sel   = (sel_cnt == MAT_SEL_W'(MAT_GRP_WORDS - 1));
  assign grp_last   = (grp_cnt == GRP_W'(NUM_GROUPS - 1));
  assign start_ok   = (state == IDLE) && start;
  assign fin        = (state == DRAIN) && m_valid && m_ready && fifo_rdata[DATA_W];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start)     state_n = WAIT_GRP;
      WAIT_GRP: if (grp_ready) state_n = READ;
      READ:     if (issue && last_sel) state_n = grp_last ? DRAIN : WAIT_GRP;
      DRAIN:    if (fin)       state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grp_cnt   <= '0;
      sel_cnt   <= '0;
      p_sel     <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      cap_valid <= 1'b0;
      cap_last  <= 1'b0;
      cap_data  <= '0;
      done      <= 1'b0;
      err_grp   <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= fin;
      pend      <= issue;
      pend_last <= issue && last_sel && grp_last;
      cap_valid <= pend;
      cap_last  <= pend_last;
      if (pend) cap_data <= p_out;

      if (start_ok) begin
        grp_cnt <= '0;
        sel_cnt <= '0;
      end else if (issue) begin
        sel_cnt <= sel_cnt + 1'b1;
        if (last_sel) grp_cnt <= grp_cnt + 1'b1;
      end

      if (start_ok)
        err_grp <= 1'b0;
      else if ((state == READ) && !grp_ready)
        err_grp <= 1'b1;

      // p_sel must stay put while its word is still being captured; it
      // parks at 0 once a group boundary has fully settled.
      if (issue)
        p_sel <= sel_cnt;
      else if (!pend && (sel_cnt == '0))
        p_sel <= '0;
    end
  end

  matrix_result_fifo #(
    .DATA_W (DATA_W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_valid),
    .wdata ({cap_last, cap_data}),
    .pop   (m_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_rdata[DATA_W-1:0];
  assign m_last    = fifo_rdata[DATA_W];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
